// File: rtl/lc3b_types.sv
// rtl/lc3b_types.sv - shared LC-3b word/mask types and memory arbiter state encoding
package lc3b_types;

  typedef logic [15:0] lc3b_word;
  typedef logic [1:0]  lc3b_mem_wmask;

  localparam int unsigned STREAK_W = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } arb_state_t;

  // Increment a streak count, sticking at the ceiling instead of wrapping.
  function automatic logic [STREAK_W-1:0] streak_inc(input logic [STREAK_W-1:0] cur,
                                                      input logic [STREAK_W-1:0] ceil);
    return (cur >= ceil) ? ceil : cur + 1'b1;
  endfunction

endpackage

// File: rtl/lc3b_arb_mux.sv
// rtl/lc3b_arb_mux.sv - steers the owner's request onto pmem and routes resp/rdata back to it
module lc3b_arb_mux
  import lc3b_types::*;
(
  input  arb_state_t    state,
  input  logic          d_is_write,
  input  logic [15:0]   i_mem_address,
  input  logic [15:0]   d_mem_address,
  input  logic [15:0]   d_mem_wdata,
  input  logic [1:0]    d_mem_byte_enable,
  input  logic [15:0]   pmem_rdata,
  input  logic          pmem_resp,
  output logic          pmem_read,
  output logic          pmem_write,
  output logic [15:0]   pmem_address,
  output logic [15:0]   pmem_wdata,
  output logic [1:0]    pmem_byte_enable,
  output logic [15:0]   i_mem_rdata,
  output logic          i_mem_resp,
  output logic [15:0]   d_mem_rdata,
  output logic          d_mem_resp
);

  // Everything idles at zero; only the current owner sees the memory and its reply.
  always_comb begin
    pmem_read        = 1'b0;
    pmem_write       = 1'b0;
    pmem_address     = '0;
    pmem_wdata       = '0;
    pmem_byte_enable = '0;
    i_mem_rdata      = '0;
    i_mem_resp       = 1'b0;
    d_mem_rdata      = '0;
    d_mem_resp       = 1'b0;
    case (state)
      SERVE_I: begin
        pmem_read    = 1'b1;
        pmem_address = i_mem_address;
        i_mem_rdata  = pmem_rdata;
        i_mem_resp   = pmem_resp;
      end
      SERVE_D: begin
        pmem_write       = d_is_write;
        pmem_read        = ~d_is_write;
        pmem_address     = d_mem_address;
        pmem_wdata       = d_mem_wdata;
        pmem_byte_enable = d_mem_byte_enable;
        d_mem_rdata      = pmem_rdata;
        d_mem_resp       = pmem_resp;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: rtl/lc3b_mem_arbiter.sv
// rtl/lc3b_mem_arbiter.sv - I/D to single memory port arbiter, D priority with fetch starvation guard (LC3B_ARB_PERF_EN adds grant/conflict counters)
module lc3b_mem_arbiter
  import lc3b_types::*;
#(
  parameter int unsigned MAX_D_STREAK = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_mem_read,
  input  logic [15:0] i_mem_address,
  output logic [15:0] i_mem_rdata,
  output logic        i_mem_resp,
  input  logic        d_mem_read,
  input  logic        d_mem_write,
  input  logic [15:0] d_mem_address,
  input  logic [15:0] d_mem_wdata,
  input  logic [1:0]  d_mem_byte_enable,
  output logic [15:0] d_mem_rdata,
  output logic        d_mem_resp,
  output logic        pmem_read,
  output logic        pmem_write,
  output logic [15:0] pmem_address,
  output logic [15:0] pmem_wdata,
  output logic [1:0]  pmem_byte_enable,
  input  logic [15:0] pmem_rdata,
  input  logic        pmem_resp
`ifdef LC3B_ARB_PERF_EN
  ,
  output logic [15:0] i_grant_cnt,
  output logic [15:0] d_grant_cnt,
  output logic [15:0] conflict_cnt
`endif
);

  localparam logic [STREAK_W-1:0] MAX_STREAK = STREAK_W'(MAX_D_STREAK);

  arb_state_t          state_q, state_d;
  logic [STREAK_W-1:0] d_streak_q, d_streak_d;
  // Write/read choice is latched at grant so the strobe survives a dropped request.
  logic                d_write_q, d_write_d;
  logic                d_req;

  assign d_req = d_mem_read | d_mem_write;

`ifdef LC3B_ARB_PERF_EN
  lc3b_word i_grant_cnt_q, i_grant_cnt_d;
  lc3b_word d_grant_cnt_q, d_grant_cnt_d;
  lc3b_word conflict_cnt_q, conflict_cnt_d;

  assign i_grant_cnt  = i_grant_cnt_q;
  assign d_grant_cnt  = d_grant_cnt_q;
  assign conflict_cnt = conflict_cnt_q;
`endif

  // Arbitration and streak bookkeeping; a grant always returns through IDLE.
  always_comb begin
    state_d    = state_q;
    d_streak_d = d_streak_q;
    d_write_d  = d_write_q;
`ifdef LC3B_ARB_PERF_EN
    i_grant_cnt_d  = i_grant_cnt_q;
    d_grant_cnt_d  = d_grant_cnt_q;
    conflict_cnt_d = conflict_cnt_q;
`endif
    case (state_q)
      IDLE: begin
`ifdef LC3B_ARB_PERF_EN
        if (i_mem_read && d_req) conflict_cnt_d = conflict_cnt_q + 16'd1;
`endif
        if (d_req && !(i_mem_read && (d_streak_q == MAX_STREAK))) begin
          state_d   = SERVE_D;
          d_write_d = d_mem_write;
        end else if (i_mem_read) begin
          state_d = SERVE_I;
        end
      end
      SERVE_I: begin
        if (pmem_resp) begin
          state_d    = IDLE;
          d_streak_d = '0;
`ifdef LC3B_ARB_PERF_EN
          i_grant_cnt_d = i_grant_cnt_q + 16'd1;
`endif
        end
      end
      SERVE_D: begin
        if (pmem_resp) begin
          state_d    = IDLE;
          d_streak_d = i_mem_read ? streak_inc(d_streak_q, MAX_STREAK) : '0;
`ifdef LC3B_ARB_PERF_EN
          d_grant_cnt_d = d_grant_cnt_q + 16'd1;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, streak and counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      d_streak_q <= '0;
      d_write_q  <= 1'b0;
`ifdef LC3B_ARB_PERF_EN
      i_grant_cnt_q  <= '0;
      d_grant_cnt_q  <= '0;
      conflict_cnt_q <= '0;
`endif
    end else begin
      state_q    <= state_d;
      d_streak_q <= d_streak_d;
      d_write_q  <= d_write_d;
`ifdef LC3B_ARB_PERF_EN
      i_grant_cnt_q  <= i_grant_cnt_d;
      d_grant_cnt_q  <= d_grant_cnt_d;
      conflict_cnt_q <= conflict_cnt_d;
`endif
    end
  end

  lc3b_arb_mux u_mux (
    .state             (state_q),
    .d_is_write        (d_write_q),
    .i_mem_address     (i_mem_address),
    .d_mem_address     (d_mem_address),
    .d_mem_wdata       (d_mem_wdata),
    .d_mem_byte_enable (d_mem_byte_enable),
    .pmem_rdata        (pmem_rdata),
    .pmem_resp         (pmem_resp),
    .pmem_read         (pmem_read),
    .pmem_write        (pmem_write),
    .pmem_address      (pmem_address),
    .pmem_wdata        (pmem_wdata),
    .pmem_byte_enable  (pmem_byte_enable),
    .i_mem_rdata       (i_mem_rdata),
    .i_mem_resp        (i_mem_resp),
    .d_mem_rdata       (d_mem_rdata),
    .d_mem_resp        (d_mem_resp)
  );

endmodule

// File: tb/tb_lc3b_mem_arbiter.sv
// tb/tb_lc3b_mem_arbiter.sv - directed self-checking bench for lc3b_mem_arbiter (LC3B_ARB_PERF_EN checks counters)
module tb_lc3b_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_mem_read;
  logic [15:0] i_mem_address;
  logic [15:0] i_mem_rdata;
  logic        i_mem_resp;
  logic        d_mem_read;
  logic        d_mem_write;
  logic [15:0] d_mem_address;
  logic [15:0] d_mem_wdata;
  logic [1:0]  d_mem_byte_enable;
  logic [15:0] d_mem_rdata;
  logic        d_mem_resp;
  logic        pmem_read;
  logic        pmem_write;
  logic [15:0] pmem_address;
  logic [15:0] pmem_wdata;
  logic [1:0]  pmem_byte_enable;
  logic [15:0] pmem_rdata;
  logic        pmem_resp;
`ifdef LC3B_ARB_PERF_EN
  logic [15:0] i_grant_cnt;
  logic [15:0] d_grant_cnt;
  logic [15:0] conflict_cnt;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  lc3b_mem_arbiter #(.MAX_D_STREAK(4)) dut (
    .clk               (clk),
    .rst               (rst),
    .i_mem_read        (i_mem_read),
    .i_mem_address     (i_mem_address),
    .i_mem_rdata       (i_mem_rdata),
    .i_mem_resp        (i_mem_resp),
    .d_mem_read        (d_mem_read),
    .d_mem_write       (d_mem_write),
    .d_mem_address     (d_mem_address),
    .d_mem_wdata       (d_mem_wdata),
    .d_mem_byte_enable (d_mem_byte_enable),
    .d_mem_rdata       (d_mem_rdata),
    .d_mem_resp        (d_mem_resp),
    .pmem_read         (pmem_read),
    .pmem_write        (pmem_write),
    .pmem_address      (pmem_address),
    .pmem_wdata        (pmem_wdata),
    .pmem_byte_enable  (pmem_byte_enable),
    .pmem_rdata        (pmem_rdata),
    .pmem_resp         (pmem_resp)
`ifdef LC3B_ARB_PERF_EN
    ,
    .i_grant_cnt       (i_grant_cnt),
    .d_grant_cnt       (d_grant_cnt),
    .conflict_cnt      (conflict_cnt)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    logic exp_d [6];
    exp_d = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};

    rst = 1'b1;
    i_mem_read = 1'b0; i_mem_address = '0;
    d_mem_read = 1'b0; d_mem_write = 1'b0; d_mem_address = '0;
    d_mem_wdata = '0; d_mem_byte_enable = '0;
    pmem_rdata = '0; pmem_resp = 1'b0;
    tick(); tick();
    #1;
    chk("rst_pmem_read", {15'd0, pmem_read}, 16'd0);
    chk("rst_pmem_write", {15'd0, pmem_write}, 16'd0);
    chk("rst_pmem_address", pmem_address, 16'h0000);
    chk("rst_i_resp", {15'd0, i_mem_resp}, 16'd0);
    chk("rst_d_rdata", d_mem_rdata, 16'h0000);

    // Lone fetch, with the requester dropping its strobe mid-transaction
    rst = 1'b0;
    tick();
    i_mem_read = 1'b1; i_mem_address = 16'h0040;
    #1 chk("f_idle_no_strobe", {15'd0, pmem_read}, 16'd0);
    tick();
    #1 chk("f_pmem_read", {15'd0, pmem_read}, 16'd1);
    chk("f_pmem_addr", pmem_address, 16'h0040);
    chk("f_pmem_write", {15'd0, pmem_write}, 16'd0);
    chk("f_pmem_be", {14'd0, pmem_byte_enable}, 16'd0);
    tick();
    i_mem_read = 1'b0;
    #1 chk("f_hold_strobe", {15'd0, pmem_read}, 16'd1);
    tick();
    pmem_resp = 1'b1; pmem_rdata = 16'h1234;
    #1 chk("f_i_resp", {15'd0, i_mem_resp}, 16'd1);
    chk("f_i_rdata", i_mem_rdata, 16'h1234);
    chk("f_d_resp_low", {15'd0, d_mem_resp}, 16'd0);
    chk("f_d_rdata_zero", d_mem_rdata, 16'h0000);
    tick();
    pmem_resp = 1'b0;
    #1 chk("f_after_read", {15'd0, pmem_read}, 16'd0);
    chk("f_after_resp", {15'd0, i_mem_resp}, 16'd0);

    // Simultaneous I read and D write: D first, bubble, then I
    rst = 1'b1;
    tick();
    rst = 1'b0;
    i_mem_read = 1'b1; i_mem_address = 16'h0100;
    d_mem_write = 1'b1; d_mem_address = 16'h2000;
    d_mem_wdata = 16'hBEEF; d_mem_byte_enable = 2'b01;
    #1 chk("s_idle_no_strobe", {15'd0, pmem_write}, 16'd0);
    tick();
    #1 chk("s_d_write", {15'd0, pmem_write}, 16'd1);
    chk("s_d_noread", {15'd0, pmem_read}, 16'd0);
    chk("s_d_addr", pmem_address, 16'h2000);
    chk("s_d_wdata", pmem_wdata, 16'hBEEF);
    chk("s_d_be", {14'd0, pmem_byte_enable}, 16'd1);
    pmem_resp = 1'b1; pmem_rdata = 16'h0000;
    #1 chk("s_d_resp", {15'd0, d_mem_resp}, 16'd1);
    chk("s_i_resp_low", {15'd0, i_mem_resp}, 16'd0);
    tick();
    pmem_resp = 1'b0; d_mem_write = 1'b0;
    #1 chk("s_bubble_read", {15'd0, pmem_read}, 16'd0);
    chk("s_bubble_write", {15'd0, pmem_write}, 16'd0);
    tick();
    #1 chk("s_i_read", {15'd0, pmem_read}, 16'd1);
    chk("s_i_addr", pmem_address, 16'h0100);
    chk("s_i_be", {14'd0, pmem_byte_enable}, 16'd0);
    pmem_resp = 1'b1; pmem_rdata = 16'h5678;
    #1 chk("s_i_resp", {15'd0, i_mem_resp}, 16'd1);
    chk("s_i_rdata", i_mem_rdata, 16'h5678);
    chk("s_d_resp_low", {15'd0, d_mem_resp}, 16'd0);
    tick();
    pmem_resp = 1'b0; i_mem_read = 1'b0;
`ifdef LC3B_ARB_PERF_EN
    #1 chk("p_conflict", conflict_cnt, 16'd1);
    chk("p_i_grant", i_grant_cnt, 16'd1);
    chk("p_d_grant", d_grant_cnt, 16'd1);
`endif

    // Starvation guard: both held, zero-wait memory -> D D D D I D
    i_mem_read = 1'b1; i_mem_address = 16'h3000;
    d_mem_read = 1'b1; d_mem_address = 16'h4000;
    for (int k = 0; k < 6; k++) begin
      pmem_resp = 1'b0;
      #1 chk($sformatf("g%0d_bubble", k), {14'd0, pmem_read, pmem_write}, 16'd0);
      tick();
      pmem_resp = 1'b1;
      #1 chk($sformatf("g%0d_d_resp", k), {15'd0, d_mem_resp}, {15'd0, exp_d[k]});
      chk($sformatf("g%0d_i_resp", k), {15'd0, i_mem_resp}, {15'd0, ~exp_d[k]});
      chk($sformatf("g%0d_addr", k), pmem_address, exp_d[k] ? 16'h4000 : 16'h3000);
      tick();
    end
    pmem_resp = 1'b0; i_mem_read = 1'b0; d_mem_read = 1'b0;
    tick();

    // Reset during SERVE_D, then a stray pmem_resp
    d_mem_read = 1'b1; d_mem_address = 16'h0050;
    tick();
    #1 chk("r_serve_read", {15'd0, pmem_read}, 16'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0; d_mem_read = 1'b0; pmem_resp = 1'b1; pmem_rdata = 16'h9999;
    #1 chk("r_strobes_low", {14'd0, pmem_read, pmem_write}, 16'd0);
    chk("r_no_d_resp", {15'd0, d_mem_resp}, 16'd0);
    chk("r_no_i_resp", {15'd0, i_mem_resp}, 16'd0);
    chk("r_d_rdata_zero", d_mem_rdata, 16'h0000);
    tick();
    pmem_resp = 1'b0;
    #1 chk("r_still_idle", {14'd0, pmem_read, pmem_write}, 16'd0);

    // Illegal read+write: write wins
    d_mem_read = 1'b1; d_mem_write = 1'b1; d_mem_address = 16'h0060;
    d_mem_wdata = 16'h1111; d_mem_byte_enable = 2'b11;
    tick();
    #1 chk("x_write", {15'd0, pmem_write}, 16'd1);
    chk("x_noread", {15'd0, pmem_read}, 16'd0);
    chk("x_be", {14'd0, pmem_byte_enable}, 16'd3);
    pmem_resp = 1'b1; pmem_rdata = 16'hAAAA;
    #1 chk("x_d_resp", {15'd0, d_mem_resp}, 16'd1);
    chk("x_d_rdata", d_mem_rdata, 16'hAAAA);
    chk("x_i_rdata_zero", i_mem_rdata, 16'h0000);
    tick();
    pmem_resp = 1'b0; d_mem_read = 1'b0; d_mem_write = 1'b0;
    #1 chk("x_after", {14'd0, pmem_read, pmem_write}, 16'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lc3b_mem_arbiter.md
Name: lc3b_mem_arbiter

Overview:
- Shares one physical memory port between the pipeline's instruction-fetch port and data port.
- Sits between the pipelined datapath (separate I/D requesters) and the single-ported memory.
- Grants one requester per transaction with registered ownership.
- Data side has priority; a starvation guard guarantees fetch progress.

Parameters:
MAX_D_STREAK, 4, consecutive D grants allowed while I is pending before I is forced next (1..15)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous active-high reset
i_mem_read  in  1  instruction fetch request, held until i_mem_resp
i_mem_address  in  16  fetch address (lc3b_word)
i_mem_rdata  out  16  fetch data, valid when i_mem_resp
i_mem_resp  out  1  one-cycle completion pulse to I side
d_mem_read  in  1  data read request, held until d_mem_resp
d_mem_write  in  1  data write request, held until d_mem_resp
d_mem_address  in  16  data address
d_mem_wdata  in  16  write data
d_mem_byte_enable  in  2  write byte mask (lc3b_mem_wmask)
d_mem_rdata  out  16  read data, valid when d_mem_resp
d_mem_resp  out  1  one-cycle completion pulse to D side
pmem_read  out  1  physical read strobe
pmem_write  out  1  physical write strobe
pmem_address  out  16  physical address
pmem_wdata  out  16  physical write data
pmem_byte_enable  out  2  physical byte mask
pmem_rdata  in  16  physical read data
pmem_resp  in  1  physical completion pulse

Behaviour:
- Clock is clk; reset is rst, synchronous and active-high.
- FSM states (arb_state_t): IDLE, SERVE_I, SERVE_D. Reset → IDLE, d_streak=0.
- All outputs are 0 in reset and in IDLE: pmem_*, *_resp, i/d_mem_rdata = 16'h0000.
- IDLE arbitration, evaluated each cycle:
  - d_req = d_mem_read|d_mem_write.
  - d_req & !(i_mem_read & d_streak==MAX_D_STREAK) → SERVE_D.
  - else i_mem_read → SERVE_I.
  - else stay in IDLE.
- The grant is registered. The request is seen in cycle N and the pmem strobe asserts in cycle N+1. Minimum latency from request to resp is 2 cycles with a zero-wait memory.
- SERVE_I:
  - pmem_read=1, pmem_address=i_mem_address, pmem_write=0, pmem_byte_enable=2'b00.
  - i_mem_rdata=pmem_rdata and i_mem_resp=pmem_resp, both combinational.
  - On pmem_resp → IDLE, d_streak=0.
- SERVE_D:
  - Address, wdata and byte_enable come from the D side.
  - If d_mem_write=1: pmem_write=1, pmem_read=0. Write wins if both are asserted (illegal combination).
  - If only d_mem_read=1: pmem_read=1.
  - d_mem_rdata/d_mem_resp pass through combinationally.
  - On pmem_resp → IDLE. If i_mem_read was pending, d_streak increments, saturating at MAX_D_STREAK; otherwise d_streak=0.
- The non-owner's resp is always 0 and its rdata is 16'h0000.
- Every transaction is followed by exactly one IDLE cycle (a bubble between back-to-back transactions).
- If a requester drops its strobe mid-transaction (protocol violation), the arbiter still holds the pmem strobe until pmem_resp and still pulses the owner's resp.
- pmem_resp in IDLE is ignored: nothing is forwarded and there is no state change.
- rst during SERVE_x: next cycle is IDLE with all strobes low. Any later stray pmem_resp is ignored.
- d_streak width is 4 bits.

Optional Feature:
- Macro: LC3B_ARB_PERF_EN.
- When defined, three 16-bit wrapping counters are added:
  - i_grant_cnt increments on each I-transaction completion.
  - d_grant_cnt increments on each D-transaction completion.
  - conflict_cnt increments on each cycle in IDLE with i_mem_read & d_req.
- Counters are exported as outputs of the same names and reset to 0.
- When not defined, the counters and ports are absent and the remaining behaviour is identical.

Decomposition:
- lc3b_types gets arb_state_t (IDLE/SERVE_I/SERVE_D). The arbiter reuses the existing lc3b_word and lc3b_mem_wmask typedefs.
- Sub-module lc3b_arb_mux is natural: a combinational 2:1 selector for the pmem request bundle plus resp/rdata demux, driven by the state.
- The FSM and streak counter stay in the top module.

Test Plan:
- Lone fetch: i_mem_read=1, address=16'h0040, pmem_resp after 3 cycles, rdata=16'h1234 → pmem_read high from cycle 1, i_mem_resp pulse with i_mem_rdata=16'h1234, d_mem_resp never high.
- Simultaneous requests: I read 16'h0100 and D write 16'h2000 (wdata=16'hBEEF, byte_enable=2'b01) asserted together → D served first (pmem_write, byte_enable=01), then one IDLE cycle, then I served.
- Starvation guard with MAX_D_STREAK=4: I held high and D re-requests immediately after each resp → exactly 4 D transactions, then 1 I transaction, then D resumes.
- Reset mid-transaction: assert rst during SERVE_D before pmem_resp, then pulse pmem_resp one cycle later → all strobes 0 the cycle after rst, no d_mem_resp, FSM in IDLE.
- Stray/illegal inputs:
  - pmem_resp while IDLE → no resp forwarded.
  - d_mem_read & d_mem_write both high → pmem_write=1, pmem_read=0.
- Perf counters (LC3B_ARB_PERF_EN defined): scenario 2 → conflict_cnt=1, i_grant_cnt=1, d_grant_cnt=1.
